// File: rtl/cap_touch_scanner.sv
// rtl/cap_touch_scanner.sv - charge/discharge timing scanner for nine capacitive pads
// Produces debounced touch flags and sticky onset events with an ack handshake.
module cap_touch_scanner #(
    parameter int NUM_PADS      = 9,
    parameter int CHARGE_CYCLES = 64,
    parameter int TIMEOUT       = 1023,
    parameter int CNT_W         = 10,
    parameter int THRESHOLD     = 200,
    parameter int DEBOUNCE      = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                scan_enable,
    input  logic [NUM_PADS-1:0] capacitive_sensors_in,
    output logic                capacitive_sensors_out,
    output logic [NUM_PADS-1:0] touch_state,
    output logic [NUM_PADS-1:0] event_pending,
    output logic                event_valid,
    input  logic                event_ack,
    output logic                scan_done
);
    localparam int CHG_W = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
    localparam logic [CHG_W-1:0] CHG_LAST = CHG_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_V     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] THR_V    = CNT_W'(THRESHOLD);
    localparam logic [2:0]       DEB_V    = 3'(DEBOUNCE);

    typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_MEASURE, S_EVAL} state_t;

    state_t              r_state, w_state_next;
    logic [NUM_PADS-1:0] r_sync1, r_sync2;
    logic [CHG_W-1:0]    r_chg_cnt;
    logic [CNT_W-1:0]    r_meas_cnt;
    logic [CNT_W-1:0]    w_meas_next;
    logic                w_meas_exit;
    logic [CNT_W-1:0]    r_count [NUM_PADS];
    logic [2:0]          r_agree [NUM_PADS];
    logic [2:0]          w_agree_next [NUM_PADS];
    logic [NUM_PADS-1:0] r_touch, w_touch_next;
    logic [NUM_PADS-1:0] r_pend, w_onset, w_raw;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= capacitive_sensors_in;
            r_sync2 <= r_sync1;
        end
    end

    // The first MEASURE cycle still sees charge-phase levels through the synchronizer.
    assign w_meas_next = r_meas_cnt + 1'b1;
    assign w_meas_exit = ((r_meas_cnt != '0) && (r_sync2 == '0)) || (w_meas_next == TO_V);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:    if (scan_enable) w_state_next = S_CHARGE;
            S_CHARGE:  if (r_chg_cnt == CHG_LAST) w_state_next = S_MEASURE;
            S_MEASURE: if (w_meas_exit) w_state_next = S_EVAL;
            S_EVAL:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_chg_cnt  <= '0;
            r_meas_cnt <= '0;
            for (int i = 0; i < NUM_PADS; i++) r_count[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (scan_enable) begin
                    r_chg_cnt  <= '0;
                    r_meas_cnt <= '0;
                    for (int i = 0; i < NUM_PADS; i++) r_count[i] <= '0;
                end
                S_CHARGE: r_chg_cnt <= r_chg_cnt + 1'b1;
                S_MEASURE: begin
                    r_meas_cnt <= w_meas_next;
                    for (int i = 0; i < NUM_PADS; i++)
                        if (r_sync2[i] && (r_count[i] != TO_V)) r_count[i] <= r_count[i] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_touch_next = r_touch;
        w_onset      = '0;
        w_raw        = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            w_agree_next[i] = r_agree[i];
            w_raw[i]        = (r_count[i] >= THR_V);
            if (r_state == S_EVAL) begin
                if (w_raw[i] == r_touch[i]) begin
                    w_agree_next[i] = '0;
                end else if ((r_agree[i] + 3'd1) == DEB_V) begin
                    w_agree_next[i] = '0;
                    w_touch_next[i] = ~r_touch[i];
                    w_onset[i]      = ~r_touch[i];
                end else begin
                    w_agree_next[i] = r_agree[i] + 3'd1;
                end
            end
        end
    end

    // A new onset wins over an ack landing in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_touch <= '0;
            r_pend  <= '0;
            for (int i = 0; i < NUM_PADS; i++) r_agree[i] <= '0;
        end else begin
            r_touch <= w_touch_next;
            r_pend  <= (r_pend & ~{NUM_PADS{event_ack}}) | w_onset;
            for (int i = 0; i < NUM_PADS; i++) r_agree[i] <= w_agree_next[i];
        end
    end

    assign capacitive_sensors_out = (r_state == S_CHARGE);
    assign scan_done              = (r_state == S_EVAL);
    assign touch_state            = r_touch;
    assign event_pending          = r_pend;
    assign event_valid            = |r_pend;

endmodule

// File: doc/cap_touch_scanner.md
# cap_touch_scanner

Sensor-side reader for the whack-a-mole touch pads: drives the shared charge line `capacitive_sensors_out`, times the RC discharge of each of the nine pads on `capacitive_sensors_in`, and converts the timings into debounced touch states. It sits between the board pins and the processor, whose LED side drives `led_pins`. It hands touch events to the processor through a sticky pending-bit / acknowledge handshake.

## Interface
- `NUM_PADS`, 9, number of pads, one bit per pad on every pad vector.
- `CHARGE_CYCLES`, 64, cycles the charge line is held high per scan (≥1).
- `TIMEOUT`, 1023, maximum measure-phase length and per-pad count saturation value.
- `CNT_W`, 10, width of the per-pad and measure counters; 2^CNT_W − 1 ≥ TIMEOUT.
- `THRESHOLD`, 200, discharge count at or above which a pad reads as touched.
- `DEBOUNCE`, 3, consecutive disagreeing scans required to flip a pad's state (1..7).
- `clock`  input  1  single system clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `scan_enable`  input  1  permits starting a new scan.
- `capacitive_sensors_in`  input  NUM_PADS  raw pad levels; asynchronous.
- `capacitive_sensors_out`  output  1  charge line; high only in CHARGE.
- `touch_state`  output  NUM_PADS  debounced touched flags.
- `event_pending`  output  NUM_PADS  sticky touch-onset flags.
- `event_valid`  output  1  OR-reduction of `event_pending`.
- `event_ack`  input  1  clears the pending bits.
- `scan_done`  output  1  one-cycle pulse when a scan completes.

## Operation
- Inputs pass through a 2-flop synchronizer (reset to 0) before use. "Sync" below means the synchronizer output.
- FSM states:
  - IDLE: go to CHARGE when `scan_enable`=1, clearing the measure counter and all pad counts.
  - CHARGE: drive out=1 for exactly CHARGE_CYCLES cycles, then go to MEASURE.
  - MEASURE: out=0. The measure counter increments every cycle. Pad count i increments each cycle sync[i]=1, saturating at TIMEOUT. Leave for EVAL when sync is all zero (checked from the 2nd MEASURE cycle on, to cover synchronizer delay) or when the measure counter reaches TIMEOUT.
  - EVAL: one cycle. raw[i] = (count[i] ≥ THRESHOLD). Debounce update as below. Pulse `scan_done`. Return to IDLE.
- Debounce, per pad, 3-bit agree counter:
  - If raw[i] = touch_state[i], the counter clears.
  - Otherwise it increments. When it reaches DEBOUNCE, touch_state[i] toggles and the counter clears.
- Event generation: a 0→1 toggle of touch_state[i] sets event_pending[i]. A 1→0 toggle sets nothing.
- Handshake:
  - `event_valid` = |event_pending, combinational from the register.
  - In a cycle with `event_ack`=1, all bits set at the start of that cycle clear.
  - A bit being set in the same cycle survives, because set has priority.
  - Ack with nothing pending has no effect.
- Deasserting `scan_enable` mid-scan does not abort: the scan runs to EVAL, then the FSM waits in IDLE.
- Reset:
  - FSM goes to IDLE. Counters, synchronizer, touch_state, event_pending and agree counters all go to 0.
  - `capacitive_sensors_out` drops to 0 asynchronously, even mid-CHARGE.

## Timing
- Reset values: out=0, touch_state=0, event_pending=0, event_valid=0, scan_done=0.
- First CHARGE cycle is the cycle after `scan_enable` is sampled high in IDLE. Out is high for CHARGE_CYCLES consecutive cycles.
- Scan length is CHARGE_CYCLES + M + 1 (EVAL) + 1 (IDLE) cycles, where M is the number of MEASURE cycles, 2 ≤ M ≤ TIMEOUT. With `scan_enable` held high, scans run back to back.
- Pad discharge lag: a pad falling at cycle t is first seen low in sync at t+2. The count includes synchronizer latency; THRESHOLD is calibrated against that.
- touch_state and event_pending update on the clock edge ending EVAL; `scan_done` is high during EVAL.
- Touch onset latency: DEBOUNCE scans after the first scan whose raw reading disagrees with the current state.

## Test plan
Parameters for all scenarios: CHARGE_CYCLES=4, TIMEOUT=31, THRESHOLD=10, DEBOUNCE=2.
- Reset then idle, `scan_enable`=0 for 20 cycles -> out=0, touch_state=0, event_valid=0, no `scan_done`.
- `scan_enable`=1, all pads low -> out high exactly 4 cycles, M=2, `scan_done` every 8 cycles, touch_state stays 0.
- Pad 3 held high 15 cycles after each charge, others 0 -> touch_state[3]=1 after the 2nd EVAL, event_pending=9'h008, event_valid=1. Release pad 3 -> touch_state[3]=0 after 2 scans with no new event.
- Pad 0 stuck high -> M=31, count[0]=31 (saturated), touch_state[0]=1 after 2 scans. Alternating touched/untouched scans on pad 5 -> touch_state[5] never changes.
- Pending bit 3, then pad 7 onset in the same EVAL cycle as `event_ack`=1 -> event_pending=9'h080 afterward. A second ack clears it to 0 and event_valid drops.
- Reset asserted during the 2nd CHARGE cycle -> out=0 immediately, all outputs 0. After release with `scan_enable`=1, a full 4-cycle charge restarts.
